// File: rtl/decode_queue.sv
// Decode queue: decodes fetched (pc, instr) pairs on entry and buffers DEPTH entries for execute.
// Optional RV32M decode is enabled by defining DECODE_MULDIV_EN.

package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic {
    am1_rs1_out = 1'b0,
    am1_pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    am2_i_imm   = 3'd0,
    am2_u_imm   = 3'd1,
    am2_b_imm   = 3'd2,
    am2_s_imm   = 3'd3,
    am2_j_imm   = 3'd4,
    am2_rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    rfm_alu_out  = 4'd0,
    rfm_br_en    = 4'd1,
    rfm_u_imm    = 4'd2,
    rfm_lw       = 4'd3,
    rfm_pc_plus4 = 4'd4,
    rfm_lb       = 4'd5,
    rfm_lbu      = 4'd6,
    rfm_lh       = 4'd7,
    rfm_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic {
    cmp_rs2_out = 1'b0,
    cmp_i_imm   = 1'b1
  } cmpmux_sel_t;

  typedef enum logic [1:0] {
    pcm_pc_plus4 = 2'd0,
    pcm_alu_out  = 2'd1,
    pcm_alu_mod2 = 2'd2
  } pcmux_sel_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    cmpmux_sel_t     cmpmux_sel;
    pcmux_sel_t      pcmux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic            commit;
    logic            muldiv;
  } rv32i_ctrl_word;

  function automatic rv32i_ctrl_word default_ctrl();
    rv32i_ctrl_word c;
    c.opcode         = '0;
    c.funct3         = '0;
    c.aluop          = alu_add;
    c.cmpop          = beq;
    c.alumux1_sel    = am1_rs1_out;
    c.alumux2_sel    = am2_i_imm;
    c.regfilemux_sel = rfm_alu_out;
    c.cmpmux_sel     = cmp_i_imm;
    c.pcmux_sel      = pcm_pc_plus4;
    c.load_regfile   = 1'b0;
    c.mem_read       = 1'b0;
    c.mem_write      = 1'b0;
    c.commit         = 1'b0;
    c.muldiv         = 1'b0;
    return c;
  endfunction

endpackage

module decode_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output rv32i_ctrl_word           out_ctrl,
  output logic                     out_illegal,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_pc      [DEPTH];
  logic [XLEN-1:0] r_instr   [DEPTH];
  rv32i_ctrl_word  r_ctrl    [DEPTH];
  logic            r_illegal [DEPTH];

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  rv32i_ctrl_word  w_ctrl;
  logic            w_illegal;

  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign count     = r_count;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  always_comb begin
    w_ctrl        = default_ctrl();
    w_ctrl.opcode = w_opcode;
    w_ctrl.funct3 = w_funct3;
    w_illegal     = 1'b0;
    case (w_opcode)
      op_lui: begin
        w_ctrl.regfilemux_sel = rfm_u_imm;
        w_ctrl.load_regfile   = 1'b1;
        w_ctrl.commit         = 1'b1;
      end
      op_auipc: begin
        w_ctrl.alumux1_sel  = am1_pc_out;
        w_ctrl.alumux2_sel  = am2_u_imm;
        w_ctrl.load_regfile = 1'b1;
        w_ctrl.commit       = 1'b1;
      end
      op_jal: begin
        w_ctrl.alumux1_sel    = am1_pc_out;
        w_ctrl.alumux2_sel    = am2_j_imm;
        w_ctrl.regfilemux_sel = rfm_pc_plus4;
        w_ctrl.pcmux_sel      = pcm_alu_out;
        w_ctrl.load_regfile   = 1'b1;
        w_ctrl.commit         = 1'b1;
      end
      op_jalr: begin
        w_ctrl.regfilemux_sel = rfm_pc_plus4;
        w_ctrl.pcmux_sel      = pcm_alu_mod2;
        w_ctrl.load_regfile   = 1'b1;
        w_ctrl.commit         = 1'b1;
      end
      op_br: begin
        w_ctrl.alumux1_sel = am1_pc_out;
        w_ctrl.alumux2_sel = am2_b_imm;
        w_ctrl.cmpop       = branch_funct3_t'(w_funct3);
        w_ctrl.cmpmux_sel  = cmp_rs2_out;
        w_ctrl.commit      = 1'b1;
      end
      op_load: begin
        w_ctrl.mem_read     = 1'b1;
        w_ctrl.load_regfile = 1'b1;
        w_ctrl.commit       = 1'b1;
        case (w_funct3)
          3'b000:  w_ctrl.regfilemux_sel = rfm_lb;
          3'b001:  w_ctrl.regfilemux_sel = rfm_lh;
          3'b010:  w_ctrl.regfilemux_sel = rfm_lw;
          3'b100:  w_ctrl.regfilemux_sel = rfm_lbu;
          3'b101:  w_ctrl.regfilemux_sel = rfm_lhu;
          default: w_illegal = 1'b1;
        endcase
      end
      op_store: begin
        w_ctrl.alumux2_sel = am2_s_imm;
        w_ctrl.mem_write   = 1'b1;
        w_ctrl.commit      = 1'b1;
      end
      op_imm: begin
        w_ctrl.load_regfile = 1'b1;
        w_ctrl.commit       = 1'b1;
        case (w_funct3)
          3'b000: w_ctrl.aluop = alu_add;
          3'b010: begin
            w_ctrl.cmpop          = blt;
            w_ctrl.regfilemux_sel = rfm_br_en;
          end
          3'b011: begin
            w_ctrl.cmpop          = bltu;
            w_ctrl.regfilemux_sel = rfm_br_en;
          end
          3'b101:  w_ctrl.aluop = w_funct7[5] ? alu_sra : alu_srl;
          default: w_ctrl.aluop = alu_ops'(w_funct3);
        endcase
      end
      op_reg: begin
        w_ctrl.alumux2_sel  = am2_rs2_out;
        w_ctrl.cmpmux_sel   = cmp_rs2_out;
        w_ctrl.load_regfile = 1'b1;
        w_ctrl.commit       = 1'b1;
        case (w_funct3)
          3'b000: w_ctrl.aluop = w_funct7[5] ? alu_sub : alu_add;
          3'b010: begin
            w_ctrl.cmpop          = blt;
            w_ctrl.regfilemux_sel = rfm_br_en;
          end
          3'b011: begin
            w_ctrl.cmpop          = bltu;
            w_ctrl.regfilemux_sel = rfm_br_en;
          end
          3'b101:  w_ctrl.aluop = w_funct7[5] ? alu_sra : alu_srl;
          default: w_ctrl.aluop = alu_ops'(w_funct3);
        endcase
        // RV32M variant travels in ctrl.funct3; the ALU fields are irrelevant for it.
`ifdef DECODE_MULDIV_EN
        if (w_funct7 == 7'b0000001) begin
          w_ctrl.muldiv         = 1'b1;
          w_ctrl.aluop          = alu_add;
          w_ctrl.cmpop          = beq;
          w_ctrl.regfilemux_sel = rfm_alu_out;
        end else if (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000) begin
          w_illegal = 1'b1;
        end
`else
        if (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000) begin
          w_illegal = 1'b1;
        end
`endif
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail]      <= in_pc;
      r_instr[r_tail]   <= in_instr;
      r_ctrl[r_tail]    <= w_ctrl;
      r_illegal[r_tail] <= w_illegal;
    end
  end

  assign out_pc      = r_pc[r_head];
  assign out_instr   = r_instr[r_head];
  assign out_ctrl    = out_valid ? r_ctrl[r_head] : default_ctrl();
  assign out_illegal = out_valid && r_illegal[r_head];

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Parametrised successor to the single-instruction combinational control ROM. Accepts fetched (pc, instruction) pairs over a valid/ready handshake and decodes each into an rv32i_ctrl_word plus an illegal flag on entry. Holds up to DEPTH decoded entries in a circular buffer between the fetch and execute stages, so fetch can run ahead while execute stalls. Supports a pipeline flush and optional RV32M decode.

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 2
XLEN, 32, width of pc and instruction data

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  queue can accept an entry this cycle
in_pc  input  XLEN  pc of the presented instruction
in_instr  input  XLEN  raw instruction word
out_valid  output  1  head entry is valid
out_ready  input  1  execute consumes the head this cycle
out_pc  output  XLEN  pc of the head entry
out_instr  output  XLEN  raw instruction of the head entry
out_ctrl  output  rv32i_ctrl_word  decoded control word of the head entry
out_illegal  output  1  head entry has an unsupported opcode or funct encoding
flush  input  1  discard all entries (branch mispredict or trap)
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n=0): head=0, tail=0, count=0; out_valid=0, in_ready=1. Storage contents are don't-care, but out_ctrl must show the default word with load_regfile=0, mem_read=0, mem_write=0 and commit=0 whenever out_valid=0.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no pass-through when the queue is full.
- out_valid = (count != 0). The head outputs are driven straight from storage, with no output register.
- Latency: an entry pushed at edge N appears at the head (out_valid=1) in the cycle after edge N if the queue was empty. There is no same-cycle bypass.
- Simultaneous push and pop while not full and not empty: count is unchanged, and both pointers advance modulo DEPTH.
- Pointers wrap from DEPTH-1 to 0. count saturates by construction, never exceeding DEPTH or going below 0.
- Flush is synchronous and takes priority. Any push or pop in the same cycle is ignored, and head, tail and count reset to 0 at that edge.
- Decode happens combinationally on in_instr before the write. Each stored entry is {pc, instr, ctrl, illegal}.
- opcode = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25]. ctrl.opcode and ctrl.funct3 carry these fields.
- Defaults for every entry: i_imm, rs1_out/imm, alu_out, pc_plus4, alu_add, cmpop beq; all enables 0.
- lui / auipc / jal / jalr / br / load / store: same field settings as the existing control ROM, with commit=1 on each.
- Load with funct3 in {011, 110, 111} sets illegal=1.
- op_imm:
  - funct3=000 always decodes as alu_add. funct7[5] is ignored, since there is no subi.
  - slt and sltu use cmpmux i_imm with blt/bltu and write back br_en.
  - sr uses funct7[5] to select alu_srl or alu_sra.
  - All other funct3 values map to alu_ops'(funct3).
- op_reg:
  - Same mapping as op_imm, except the second ALU operand is rs2_out and compares use cmpmux rs2_out.
  - funct3=000 with funct7[5]=1 decodes as alu_sub.
  - funct7 values other than 0000000 and 0100000 set illegal=1, unless the optional feature claims them.
- op_csr and any unknown opcode: illegal=1, commit=0, load_regfile=0, mem_read=0, mem_write=0. The entry is still queued so execute can raise the trap in program order.
- A reset asserted mid-operation drops all entries immediately. No partial push survives.

Optional Feature:
Macro DECODE_MULDIV_EN.
- Defined: op_reg with funct7=0000001 decodes as RV32M and sets ctrl.muldiv=1. The variant number is carried in ctrl.funct3: 0=mul, 1=mulh, 2=mulhsu, 3=mulhu, 4=div, 5=divu, 6=rem, 7=remu. load_regfile=1, commit=1, illegal=0.
- Not defined: ctrl.muldiv is tied to 0, and funct7=0000001 on op_reg sets illegal=1.

Test Plan:
- Reset, then push lui x1,0x12345 (0x123450B7) at pc 0x60 with out_ready=0 -> next cycle out_valid=1, out_pc=0x60, regfilemux u_imm, load_regfile=1, count=1.
- Push 4 entries with out_ready=0 -> in_ready=0 once count=4; a 5th in_valid is not accepted; then pop 4 -> entries leave in order, and count and in_ready recover.
- Stream 10 entries with in_valid=1 and out_ready=1 on every cycle -> steady state count=1, each pc appears exactly once and in order, pointers wrap correctly.
- Flush on the same cycle as push and pop with count=3 -> count=0, out_valid=0 next cycle, and the pushed entry is lost.
- Decode checks: push 0x40000033 (sub) -> alu_sub; push 0x40000013 (addi with funct7[5]=1) -> alu_add; push 0x00000073 (csr) -> out_illegal=1, commit=0.
- Push 0x02208033 (mul) -> with DECODE_MULDIV_EN: muldiv=1, illegal=0; without it: illegal=1.
